arp_responder: RTL

- Downstream consumer of the network configuration outputs for one port: takes MYIPADDR/MYMACADDR and answers ARP requests for that IP.
- Sits between the MAC RX byte stream and a TX arbiter input.
- Parses incoming Ethernet frames byte by byte, detects ARP requests targeting this port's IP, and emits a 60-byte ARP reply frame without FCS. The MAC appends the FCS.

---
 rtl/arp_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/arp_responder.sv
// ARP responder: parses RX Ethernet frames, answers ARP requests for this port's IP
// with a FRAME_LEN-byte reply (no FCS) on a valid/ready TX byte stream.
module arp_responder #(
    parameter int FRAME_LEN = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MYIPADDR_i,
    input  logic [47:0] MYMACADDR_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic [15:0] arp_req_count,
    output logic [15:0] arp_reply_count
);
    typedef enum logic [1:0] {IDLE, RX, DROP, TX} state_t;

    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    state_t      state_q, state_d;
    logic        rx_ready_q, rx_ready_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  tx_idx_q, tx_idx_d;
    logic [31:0] my_ip_q, my_ip_d;
    logic [47:0] my_mac_q, my_mac_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic        bc_ok_q, bc_ok_d;
    logic        mac_ok_q, mac_ok_d;
    logic        tpa_ok_q, tpa_ok_d;
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [15:0] rep_cnt_q, rep_cnt_d;
    logic        fmt_ok;
    logic        rx_beat;
    logic [7:0]  tx_byte;

    // Byte k (0 = most significant) of a 48/32-bit field.
    function automatic logic [7:0] b48(input logic [47:0] v, input logic [5:0] k);
        return 8'(v >> {(6'd5 - k), 3'b000});
    endfunction

    function automatic logic [7:0] b32(input logic [31:0] v, input logic [5:0] k);
        return 8'(v >> {(6'd3 - k), 3'b000});
    endfunction

    assign rx_beat = rx_valid & rx_ready_q;

    // Fixed ARP request header bytes: Ethertype, HTYPE, PTYPE, HLEN, PLEN, OPER=request.
    always_comb begin
        fmt_ok = 1'b1;
        case (idx_q)
            6'd12, 6'd16: fmt_ok = (rx_data == 8'h08);
            6'd13:        fmt_ok = (rx_data == 8'h06);
            6'd14, 6'd17,
            6'd20:        fmt_ok = (rx_data == 8'h00);
            6'd15, 6'd21: fmt_ok = (rx_data == 8'h01);
            6'd18:        fmt_ok = (rx_data == 8'h06);
            6'd19:        fmt_ok = (rx_data == 8'h04);
            default:      fmt_ok = 1'b1;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        case (tx_idx_q) inside
            [6'd0:6'd5]:   tx_byte = b48(sha_q, tx_idx_q);
            [6'd6:6'd11]:  tx_byte = b48(my_mac_q, tx_idx_q - 6'd6);
            6'd12, 6'd16:  tx_byte = 8'h08;
            6'd13, 6'd18:  tx_byte = 8'h06;
            6'd15:         tx_byte = 8'h01;
            6'd19:         tx_byte = 8'h04;
            6'd21:         tx_byte = 8'h02;
            [6'd22:6'd27]: tx_byte = b48(my_mac_q, tx_idx_q - 6'd22);
            [6'd28:6'd31]: tx_byte = b32(my_ip_q, tx_idx_q - 6'd28);
            [6'd32:6'd37]: tx_byte = b48(sha_q, tx_idx_q - 6'd32);
            [6'd38:6'd41]: tx_byte = b32(spa_q, tx_idx_q - 6'd38);
            default:       tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_idx_d  = tx_idx_q;
        my_ip_d   = my_ip_q;
        my_mac_d  = my_mac_q;
        sha_d     = sha_q;
        spa_d     = spa_q;
        bc_ok_d   = bc_ok_q;
        mac_ok_d  = mac_ok_q;
        tpa_ok_d  = tpa_ok_q;
        req_cnt_d = req_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (rx_beat) begin
                    // Byte 0 compares against the live MAC since the snapshot lands this edge.
                    my_ip_d  = MYIPADDR_i;
                    my_mac_d = MYMACADDR_i;
                    bc_ok_d  = (rx_data == 8'hFF);
                    mac_ok_d = (rx_data == MYMACADDR_i[47:40]);
                    tpa_ok_d = 1'b1;
                    idx_d    = 6'd1;
                    state_d  = rx_last ? IDLE : RX;
                end
            end
            RX: begin
                if (rx_beat) begin
                    idx_d = (idx_q >= 6'd42) ? 6'd42 : idx_q + 6'd1;
                    if (idx_q <= 6'd5) begin
                        bc_ok_d  = bc_ok_q & (rx_data == 8'hFF);
                        mac_ok_d = mac_ok_q & (rx_data == b48(my_mac_q, idx_q));
                    end
                    if (idx_q >= 6'd22 && idx_q <= 6'd27) sha_d = {sha_q[39:0], rx_data};
                    if (idx_q >= 6'd28 && idx_q <= 6'd31) spa_d = {spa_q[23:0], rx_data};
                    if (idx_q >= 6'd38 && idx_q <= 6'd41)
                        tpa_ok_d = tpa_ok_q & (rx_data == b32(my_ip_q, idx_q - 6'd38));
                    if (!fmt_ok) begin
                        state_d = rx_last ? IDLE : DROP;
                    end else if (rx_last) begin
                        state_d = IDLE;
                        if (idx_q >= 6'd41) begin
                            req_cnt_d = req_cnt_q + 16'd1;
                            if ((bc_ok_d | mac_ok_d) & tpa_ok_d) begin
                                state_d  = TX;
                                tx_idx_d = 6'd0;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (rx_beat && rx_last) state_d = IDLE;
            end
            TX: begin
                if (tx_ready) begin
                    if (tx_idx_q == LAST_IDX) begin
                        rep_cnt_d = rep_cnt_q + 16'd1;
                        state_d   = IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        rx_ready_d = (state_d != TX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            idx_q      <= 6'd0;
            tx_idx_q   <= 6'd0;
            my_ip_q    <= 32'd0;
            my_mac_q   <= 48'd0;
            sha_q      <= 48'd0;
            spa_q      <= 32'd0;
            bc_ok_q    <= 1'b0;
            mac_ok_q   <= 1'b0;
            tpa_ok_q   <= 1'b0;
            req_cnt_q  <= 16'd0;
            rep_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            idx_q      <= idx_d;
            tx_idx_q   <= tx_idx_d;
            my_ip_q    <= my_ip_d;
            my_mac_q   <= my_mac_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            bc_ok_q    <= bc_ok_d;
            mac_ok_q   <= mac_ok_d;
            tpa_ok_q   <= tpa_ok_d;
            req_cnt_q  <= req_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign rx_ready        = rx_ready_q;
    assign tx_valid        = (state_q == TX);
    assign tx_last         = tx_valid & (tx_idx_q == LAST_IDX);
    assign tx_data         = tx_valid ? tx_byte : 8'h00;
    assign arp_req_count   = req_cnt_q;
    assign arp_reply_count = rep_cnt_q;
endmodule
